// File: rtl/dcache_wbuffer.sv
// Write-back buffer between the data cache and the memory write port: coalesces dirty line fragments and forwards them to refill lookups.
// Latency: a lookup result is registered (1 cycle); the first mem_req_o comes 2 cycles after a push into an empty buffer; drain is >=2 cycles per entry.
// Backpressure: cpu_wready_o drops when full (unless the write merges) or while flushing; mem_req_o and its fields hold until mem_ready_i.
module dcache_wbuffer #(
  parameter int DEPTH      = 8,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_wreq_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_awaddr_i,
  input  logic [LINE_WIDTH-1:0]     cpu_wdata_i,
  input  logic [LINE_WIDTH/8-1:0]   cpu_wstrb_i,
  output logic                      cpu_wready_o,
  input  logic                      cpu_rreq_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_araddr_i,
  output logic                      read_hit_o,
  output logic [LINE_WIDTH-1:0]     cpu_rdata_o,
  output logic [LINE_WIDTH/8-1:0]   cpu_rstrb_o,
  output logic                      mem_req_o,
  input  logic                      mem_ready_i,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [LINE_WIDTH-1:0]     mem_data_o,
  output logic [LINE_WIDTH/8-1:0]   mem_strb_o,
  input  logic                      mem_bvalid_i,
  input  logic                      flush_i,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      flush_done_o
);

  localparam int STRB_W   = LINE_WIDTH / 8;
  localparam int OFFSET_W = $clog2(STRB_W);
  localparam int TAG_W    = ADDR_WIDTH - OFFSET_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_B = 2'd2
  } state_e;

  // Drain FSM and queue bookkeeping
  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Entry storage; the line address is kept as a tag (offset bits are implicitly zero)
  logic               valid_q [DEPTH];
  logic               valid_d [DEPTH];
  logic [TAG_W-1:0]   tag_q   [DEPTH];
  logic [TAG_W-1:0]   tag_d   [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [LINE_WIDTH-1:0] data_d [DEPTH];
  logic [STRB_W-1:0]  strb_q  [DEPTH];
  logic [STRB_W-1:0]  strb_d  [DEPTH];

  // Registered lookup result
  logic                  read_hit_q, read_hit_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic [STRB_W-1:0]     rstrb_q, rstrb_d;

  logic [TAG_W-1:0]   wr_tag;
  logic [TAG_W-1:0]   rd_tag;
  logic               head_inflight;
  logic               head_locked;
  logic               merge_hit;
  logic [PTR_W-1:0]   merge_idx;
  logic               rd_young_hit;
  logic [PTR_W-1:0]   rd_young_idx;
  logic               rd_old_hit;
  logic               wr_fire;
  logic               push;
  logic               merge;
  logic               pop;
  logic               unused_offset_bits;

  assign wr_tag = cpu_awaddr_i[ADDR_WIDTH-1:OFFSET_W];
  assign rd_tag = cpu_araddr_i[ADDR_WIDTH-1:OFFSET_W];
  assign unused_offset_bits = ^{cpu_awaddr_i[OFFSET_W-1:0], cpu_araddr_i[OFFSET_W-1:0]};

  // The head is in flight once memory has accepted it. It is also excluded from
  // merging in the very cycle it is being accepted, otherwise the merged bytes
  // would be lost because memory already captured the old fields.
  assign head_inflight = (state_q == ST_WAIT_B);
  assign head_locked   = head_inflight || ((state_q == ST_REQ) && mem_ready_i);

  // Status flags derived from the occupancy count and the flush level
  always_comb begin
    empty_o      = (count_q == '0);
    full_o       = (count_q == CNT_W'(DEPTH));
    flush_done_o = flush_i && empty_o;
    cpu_wready_o = !flush_i && (merge_hit || !full_o);
  end

  // Write tag match: at most one mergeable (non-in-flight) entry per line exists
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == wr_tag) &&
          !(head_locked && (PTR_W'(i) == head_q))) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end

  // Lookup tag match: the younger non-in-flight copy wins over the in-flight head
  always_comb begin
    rd_young_hit = 1'b0;
    rd_young_idx = '0;
    rd_old_hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == rd_tag)) begin
        if (head_inflight && (PTR_W'(i) == head_q)) begin
          rd_old_hit = 1'b1;
        end else begin
          rd_young_hit = 1'b1;
          rd_young_idx = PTR_W'(i);
        end
      end
    end
  end

  // Handshake qualifiers and occupancy update
  always_comb begin
    wr_fire = cpu_wreq_i && cpu_wready_o;
    push    = wr_fire && !merge_hit;
    merge   = wr_fire && merge_hit;
    pop     = (state_q == ST_WAIT_B) && mem_bvalid_i;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Drain FSM next state; a completion with entries left goes straight back to REQ
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_o) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ready_i) state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (mem_bvalid_i) state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry array update: pop at head, allocate at tail, or byte-merge into a match
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    strb_d  = strb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tag_d[tail_q]   = wr_tag;
      data_d[tail_q]  = cpu_wdata_i;
      strb_d[tail_q]  = cpu_wstrb_i;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (merge) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (cpu_wstrb_i[b]) data_d[merge_idx][8*b +: 8] = cpu_wdata_i[8*b +: 8];
      end
      strb_d[merge_idx] = strb_q[merge_idx] | cpu_wstrb_i;
    end
  end

  // Lookup result capture; a miss reports zero strobes and zero data
  always_comb begin
    read_hit_d = 1'b0;
    rdata_d    = '0;
    rstrb_d    = '0;
    if (cpu_rreq_i && (rd_young_hit || rd_old_hit)) begin
      read_hit_d = 1'b1;
      rdata_d    = rd_young_hit ? data_q[rd_young_idx] : data_q[head_q];
      rstrb_d    = rd_young_hit ? strb_q[rd_young_idx] : strb_q[head_q];
    end
  end

  // State registers; reset discards every entry immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      read_hit_q <= 1'b0;
      rdata_q    <= '0;
      rstrb_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
        strb_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      read_hit_q <= read_hit_d;
      rdata_q    <= rdata_d;
      rstrb_q    <= rstrb_d;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        tag_q[i]   <= tag_d[i];
        data_q[i]  <= data_d[i];
        strb_q[i]  <= strb_d[i];
      end
    end
  end

  // Memory request presents the head entry; lookup outputs come from registers
  always_comb begin
    mem_req_o   = (state_q == ST_REQ);
    mem_addr_o  = {tag_q[head_q], {OFFSET_W{1'b0}}};
    mem_data_o  = data_q[head_q];
    mem_strb_o  = strb_q[head_q];
    read_hit_o  = read_hit_q;
    cpu_rdata_o = rdata_q;
    cpu_rstrb_o = rstrb_q;
  end

endmodule
